// File: rtl/kbd_fifo.sv
// Keystroke FIFO with Apple-1 PIA-style KBD/KBDCR read registers.
// Keys are queued from the keyboard sources. The CPU reads them at 0xD010 (KBD)
// and polls "key ready" at 0xD011 (KBDCR).
module kbd_fifo #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12,
  parameter bit UPCASE      = 1'b1
) (
  input  logic                     clk25,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [6:0]               key_data,
  input  logic                     flush,
  input  logic                     cs,
  input  logic                     enable,
  input  logic                     w_en,
  input  logic                     address,
  output logic [7:0]               dout,
  output logic                     afull,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AFULL_CNT = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [6:0]    last_pop;
  logic [6:0]    push_data;
  logic [6:0]    head_data;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          rd_kbd;
  logic          rd_kbdcr;
  logic          do_write;
  logic          ovf_set;

  // Optional lower-to-upper case folding of incoming keys ('a'..'z' only)
  always_comb begin
    push_data = key_data;
    if (UPCASE && (key_data >= 7'h61) && (key_data <= 7'h7A))
      push_data = key_data & 7'h5F;
  end

  // Push/pop/overflow decisions; flush masks both push and pop
  always_comb begin
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    push_req = key_valid & ~flush;
    rd_kbd   = cs & enable & ~w_en & ~address & ~empty & ~flush;
    rd_kbdcr = cs & enable & ~w_en & address;
    // When full, a same-cycle pop frees the slot that wr_ptr already points at
    do_write = push_req & (~full | rd_kbd);
    ovf_set  = push_req & full & ~rd_kbd;
  end

  // Key storage; contents need no reset because count gates visibility
  always_ff @(posedge clk25) begin
    if (do_write)
      mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy, sticky overflow and the last popped key
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_pop <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_kbd) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        last_pop <= mem[rd_ptr];
      end
      case ({do_write, rd_kbd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ovf_set)
        overflow <= 1'b1;
      else if (rd_kbdcr)
        overflow <= 1'b0;
    end
  end

  // Registered occupancy reporting, one cycle behind count
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      level <= '0;
      afull <= 1'b0;
    end else begin
      level <= count;
      afull <= (count >= AFULL_CNT);
    end
  end

  // Register read mux; an empty queue keeps showing the last popped key
  always_comb begin
    head_data = empty ? last_pop : mem[rd_ptr];
    if (address)
      dout = {~empty, overflow, 6'b0};
    else
      dout = {1'b1, head_data};
  end

endmodule

// File: tb/tb_kbd_fifo.sv
// Self-checking bench for kbd_fifo: directed steps plus randomized traffic,
// checked each cycle against a queue-based reference model.
module tb_kbd_fifo;

  logic       clk25 = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [6:0] key_data;
  logic       flush;
  logic       cs;
  logic       enable;
  logic       w_en;
  logic       address;
  logic [7:0] dout;
  logic       afull;
  logic [4:0] level;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Reference model state
  logic [6:0] q[$];
  logic       m_ovf  = 1'b0;
  logic [6:0] m_last = '0;
  int         m_lvl  = 0;

  kbd_fifo #(.DEPTH(16), .AFULL_LEVEL(12), .UPCASE(1'b1)) dut (
    .clk25     (clk25),
    .rst       (rst),
    .key_valid (key_valid),
    .key_data  (key_data),
    .flush     (flush),
    .cs        (cs),
    .enable    (enable),
    .w_en      (w_en),
    .address   (address),
    .dout      (dout),
    .afull     (afull),
    .level     (level)
  );

  always #20 clk25 = ~clk25;

  function automatic logic [7:0] exp_dout();
    if (address)
      return {(q.size() != 0), m_ovf, 6'b0};
    else if (q.size() != 0)
      return {1'b1, q[0]};
    else
      return {1'b1, m_last};
  endfunction

  task automatic check(input string tag);
    logic [7:0] e;
    logic [4:0] el;
    logic       ea;
    e  = exp_dout();
    el = 5'(m_lvl);
    ea = (m_lvl >= 12);
    vectors++;
    assert (dout === e) else begin
      errors++;
      $error("FAIL %s dout: got %h expected %h", tag, dout, e);
    end
    vectors++;
    assert (level === el) else begin
      errors++;
      $error("FAIL %s level: got %0d expected %0d", tag, level, el);
    end
    vectors++;
    assert (afull === ea) else begin
      errors++;
      $error("FAIL %s afull: got %b expected %b", tag, afull, ea);
    end
  endtask

  task automatic chk_const(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_last = '0;
    m_lvl  = 0;
  endtask

  // One clock edge of the reference model, from the currently driven inputs
  task automatic model_edge();
    int         n;
    bit         pop;
    bit         crr;
    bit         setv;
    logic [6:0] d;
    n     = q.size();
    m_lvl = n;
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = cs && enable && !w_en && !address && (n != 0);
      crr  = cs && enable && !w_en && address;
      setv = 1'b0;
      d    = key_data;
      if (d >= 7'h61 && d <= 7'h7A) d = d - 7'h20;
      if (pop) m_last = q.pop_front();
      if (key_valid) begin
        if (n < 16 || pop) q.push_back(d);
        else setv = 1'b1;
      end
      if (setv) m_ovf = 1'b1;
      else if (crr) m_ovf = 1'b0;
    end
  endtask

  task automatic cyc(input logic kv, input logic [6:0] kd, input logic fl,
                     input logic c, input logic en, input logic we, input logic ad,
                     input string tag);
    key_valid = kv;
    key_data  = kd;
    flush     = fl;
    cs        = c;
    enable    = en;
    w_en      = we;
    address   = ad;
    #1;
    check(tag);
    @(posedge clk25);
    model_edge();
    @(negedge clk25);
  endtask

  task automatic push(input logic [6:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "push");
  endtask

  task automatic pop_kbd();
    cyc(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "pop");
  endtask

  task automatic rd_cr();
    cyc(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "kbdcr");
  endtask

  task automatic idle(input logic ad);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, ad, "idle");
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_data = '0; flush = 1'b0;
    cs = 1'b0; enable = 1'b0; w_en = 1'b0; address = 1'b0;
    model_reset();
    @(negedge clk25);
    #1 check("reset_kbd");
    address = 1'b1;
    #1 check("reset_kbdcr");
    @(negedge clk25);
    rst = 1'b0;

    // Single key
    push(7'h41);
    idle(1'b1);
    #1 chk_const("single_kbdcr_ready", dout, 8'h80);
    address = 1'b0;
    #1 chk_const("single_kbd", dout, 8'hC1);
    pop_kbd();
    idle(1'b1);
    #1 chk_const("single_kbdcr_empty", dout, 8'h00);
    idle(1'b1);

    // Case conversion
    push(7'h61); push(7'h7A); push(7'h7B);
    idle(1'b0);
    #1 chk_const("upcase_a", dout, 8'hC1);
    pop_kbd();
    #1 chk_const("upcase_z", dout, 8'hDA);
    pop_kbd();
    #1 chk_const("upcase_brace", dout, 8'hFB);
    pop_kbd();
    idle(1'b0);

    // Fill and overflow
    for (int i = 0; i < 16; i++) push(7'(8'h30 + i));
    push(7'h40);
    idle(1'b1); idle(1'b1);
    #1 chk_const("fill_level", 8'(level), 8'd16);
    chk_const("fill_afull", 8'(afull), 8'd1);
    chk_const("fill_kbdcr", dout, 8'hC0);
    // writes never disturb state
    cyc(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "write_cr");
    cyc(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "write_kbd");
    // overflow set while KBDCR is read: set wins
    cyc(1'b1, 7'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "ovf_set_vs_clr");
    rd_cr();
    #1 chk_const("ovf_cleared", dout, 8'h80);
    for (int i = 0; i < 16; i++) pop_kbd();
    idle(1'b0); idle(1'b0);

    // Simultaneous push and pop when full
    for (int i = 0; i < 16; i++) push(7'(8'h50 + i));
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 7'(8'h21 + i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "full_push_pop");
    idle(1'b1); idle(1'b1);
    #1 chk_const("full_pp_level", 8'(level), 8'd16);
    chk_const("full_pp_kbdcr", dout, 8'h80);
    for (int i = 0; i < 16; i++) pop_kbd();
    idle(1'b0);

    // Enable gating
    push(7'h31); push(7'h32);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "no_enable");
    #1 chk_const("gate_level", 8'(level), 8'd2);
    pop_kbd();
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "no_enable2");
    #1 chk_const("gate_level_after", 8'(level), 8'd1);
    pop_kbd();

    // Flush with a colliding push
    for (int i = 0; i < 5; i++) push(7'(8'h61 + i));
    cyc(1'b1, 7'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "flush");
    idle(1'b1); idle(1'b1);
    #1 chk_const("flush_level", 8'(level), 8'd0);
    chk_const("flush_kbdcr", dout, 8'h00);

    // Randomized traffic: push-heavy then read-heavy
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) < 75), 7'($urandom), ($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < 10), 1'($urandom), "rand_fill");
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) < 30), 7'($urandom), ($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 10), 1'($urandom), "rand_drain");

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) push(7'(8'h41 + i));
    address = 1'b0;
    #5 rst = 1'b1;
    model_reset();
    #1 check("async_rst_kbd");
    chk_const("async_rst_kbd_const", dout, 8'h80);
    address = 1'b1;
    #1 check("async_rst_kbdcr");
    chk_const("async_rst_level", 8'(level), 8'd0);
    @(posedge clk25);
    @(negedge clk25);
    rst = 1'b0;
    idle(1'b1);
    push(7'h7A);
    idle(1'b0);
    pop_kbd();
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
